reply_frame_gen: RTL



---
 rtl/reply_frame_gen.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/reply_frame_gen.sv
// Reply/telemetry frame generator: turns accept/reject pulses and heartbeat ticks
// into 8-byte frames (EB 90 CK ID CODE ST 09 D7) pushed one byte at a time into the UART TX FIFO.
module reply_frame_gen #(
    parameter int unsigned CNT_W      = 5,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [7:0]  DEV_ID     = 8'hBA,
    parameter logic [31:0] HB_PERIOD  = 32'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ack_req,
    input  logic             nak_req,
    input  logic [7:0]       cmd_code,
    input  logic             switch,
    input  logic             com_swi,
    input  logic             power_on_A,
    input  logic             power_on_B,
    input  logic             reset_a_signal,
    input  logic             reset_b_signal,
    input  logic             link_idle,
    input  logic             fwd_push,
    input  logic [CNT_W-1:0] tf_counter,
    output logic             tf_push,
    output logic [7:0]       tdr,
    output logic             busy,
    output logic             req_lost
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, PUSH, GAP} state_t;
    typedef enum logic [1:0] {KIND_ACK, KIND_NAK, KIND_HB} kind_t;

    state_t      state, state_nxt;
    logic        pend_valid;
    kind_t       pend_kind, req_kind, cur_kind;
    logic [7:0]  pend_code, req_code, cur_code;
    logic [31:0] hb_cnt;
    logic        hb_tick, new_req, consume, push_ok;
    logic [7:0]  frm_ck, frm_st, st_now, byte_sel, tdr_q;
    logic [2:0]  idx;

    assign hb_tick = (HB_PERIOD != 32'd0) && (hb_cnt == HB_PERIOD - 32'd1);
    assign consume = (state == IDLE) && pend_valid && link_idle;
    assign new_req = nak_req || ack_req || hb_tick;
    assign push_ok = !fwd_push && (tf_counter < DEPTH_C);

    always_comb begin
        req_kind = KIND_HB;
        req_code = 8'h00;
        if (nak_req) begin
            req_kind = KIND_NAK;
            req_code = 8'hEE;
        end else if (ack_req) begin
            req_kind = KIND_ACK;
            req_code = cmd_code;
        end
    end

    // A request landing in the consume cycle becomes the next pending, not a loss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_kind  <= KIND_HB;
            pend_code  <= '0;
            req_lost   <= 1'b0;
        end else begin
            req_lost <= new_req && pend_valid && !consume;
            if (new_req) begin
                pend_valid <= 1'b1;
                pend_kind  <= req_kind;
                pend_code  <= req_code;
            end else if (consume) begin
                pend_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hb_cnt <= '0;
        else if (HB_PERIOD == 32'd0 || consume || hb_tick)
            hb_cnt <= '0;
        else
            hb_cnt <= hb_cnt + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (consume) state_nxt = LOAD;
            LOAD:    state_nxt = PUSH;
            PUSH:    if (push_ok) state_nxt = GAP;
            GAP:     state_nxt = (idx == 3'd7) ? IDLE : PUSH;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tf_push = (state == PUSH) && push_ok;
        busy    = (state != IDLE);
        tdr     = tf_push ? byte_sel : tdr_q;
    end

    assign st_now = {cur_kind == KIND_ACK, cur_kind == KIND_NAK, reset_b_signal, reset_a_signal,
                     power_on_B, power_on_A, com_swi, switch};

    always_comb begin
        case (idx)
            3'd0:    byte_sel = 8'hEB;
            3'd1:    byte_sel = 8'h90;
            3'd2:    byte_sel = frm_ck;
            3'd3:    byte_sel = DEV_ID;
            3'd4:    byte_sel = cur_code;
            3'd5:    byte_sel = frm_st;
            3'd6:    byte_sel = 8'h09;
            default: byte_sel = 8'hD7;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_kind <= KIND_HB;
            cur_code <= '0;
            frm_ck   <= '0;
            frm_st   <= '0;
            tdr_q    <= '0;
            idx      <= '0;
        end else begin
            if (consume) begin
                cur_kind <= pend_kind;
                cur_code <= pend_code;
            end
            if (state == LOAD) begin
                frm_st <= st_now;
                frm_ck <= 8'h00 - DEV_ID - cur_code - st_now;
                idx    <= '0;
            end
            if (tf_push)
                tdr_q <= byte_sel;
            if (state == GAP && idx != 3'd7)
                idx <= idx + 3'd1;
        end
    end

endmodule
